// File: rtl/cordic_iter_param_if.sv
// Handshake bundle for the iterative CORDIC cosine unit.
// Optional macro CORDIC_SIN_OUT_EN adds the result_sin signal.
interface cordic_iter_param_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [31:0]      dataa;
    logic             busy;
    logic             done;
    logic             range_err;
    logic [WIDTH-1:0] result;
`ifdef CORDIC_SIN_OUT_EN
    logic [WIDTH-1:0] result_sin;

    modport master (
        output start, dataa,
        input  busy, done, range_err, result, result_sin
    );

    modport slave (
        input  start, dataa,
        output busy, done, range_err, result, result_sin
    );
`else
    modport master (
        output start, dataa,
        input  busy, done, range_err, result
    );

    modport slave (
        input  start, dataa,
        output busy, done, range_err, result
    );
`endif
endinterface

// File: rtl/cordic_iter_param.sv
// Iterative CORDIC cosine unit: float32 angle in radians -> cos(angle) in
// signed Q1.(WIDTH-1). One operation in flight, start/done handshake.
// Optional macro CORDIC_SIN_OUT_EN exports sin(angle) on result_sin.
module cordic_iter_param #(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 16
) (
    input  logic               clock,
    input  logic               aclr,
    input  logic               clk_en,
    cordic_iter_param_if.slave bus
);

    localparam int          ITER_W   = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [31:0] K_GAIN32 = 32'h4DBA76D4;
    localparam logic [WIDTH-1:0] K_GAIN = K_GAIN32[31 -: WIDTH];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROTATE,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ITER_W-1:0]       iter;
    logic                    last_iter;
    logic signed [WIDTH-1:0] x, y, z;
    logic signed [WIDTH-1:0] x_sh, y_sh, atan_w;
    logic signed [WIDTH-1:0] x_step, y_step, z_step;
    logic [31:0]             atan32;
    logic signed [WIDTH-1:0] angle_in;
    logic                    range_in;
    logic                    busy_q, done_q, range_q;
    logic signed [WIDTH-1:0] result_q;
`ifdef CORDIC_SIN_OUT_EN
    logic signed [WIDTH-1:0] result_sin_q;
`endif

    // atan(2^-i) * 2^31, i = 0..23
    function automatic logic [31:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    return 32'h6487ED51;
            5'd1:    return 32'h3B58CE0A;
            5'd2:    return 32'h1F5B75F8;
            5'd3:    return 32'h0FEADD4C;
            5'd4:    return 32'h07FD56EC;
            5'd5:    return 32'h03FFAAB6;
            5'd6:    return 32'h01FFF554;
            5'd7:    return 32'h00FFFEAA;
            5'd8:    return 32'h007FFFD5;
            5'd9:    return 32'h003FFFFB;
            5'd10:   return 32'h001FFFFF;
            5'd11:   return 32'h00100000;
            5'd12:   return 32'h00080000;
            5'd13:   return 32'h00040000;
            5'd14:   return 32'h00020000;
            5'd15:   return 32'h00010000;
            5'd16:   return 32'h00008000;
            5'd17:   return 32'h00004000;
            5'd18:   return 32'h00002000;
            5'd19:   return 32'h00001000;
            5'd20:   return 32'h00000800;
            5'd21:   return 32'h00000400;
            5'd22:   return 32'h00000200;
            5'd23:   return 32'h00000100;
            default: return 32'h00000000;
        endcase
    endfunction

    // Symmetric saturation: only the most negative code is out of range.
    function automatic logic signed [WIDTH-1:0] sat_sym(input logic signed [WIDTH-1:0] v);
        if (v == {1'b1, {(WIDTH-1){1'b0}}})
            return {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
        return v;
    endfunction

    // Float32 radians -> signed Q1.(WIDTH-1); MSB of the return is the clamp flag.
    function automatic logic [WIDTH:0] float_to_fix(input logic [31:0] f);
        logic [7:0]       e;
        logic [31:0]      m32;
        logic [WIDTH-1:0] mag;
        logic             rng;
        e   = f[30:23];
        m32 = 32'h0;
        mag = '0;
        rng = 1'b0;
        if (e == 8'd0) begin
            mag = '0;
        end else if (e <= 8'd126) begin
            m32 = {1'b1, f[22:0], 8'b0} >> (8'd127 - e);
            mag = m32[31 -: WIDTH];
        end else begin
            mag = {1'b0, {(WIDTH-1){1'b1}}};
            rng = 1'b1;
        end
        if (f[31])
            mag = -mag;
        return {rng, mag};
    endfunction

    assign last_iter = (iter == ITER_W'(ITERATIONS - 1));
    assign {range_in, angle_in} = float_to_fix(bus.dataa);

    // State register; clk_en freezes the sequence.
    always_ff @(posedge clock) begin
        if (aclr)
            state <= ST_IDLE;
        else if (clk_en)
            state <= state_nxt;
    end

    // Next-state: accept in IDLE, ITERATIONS rotate cycles, one DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.start) state_nxt = ST_ROTATE;
            ST_ROTATE: if (last_iter) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // One rotation step; direction follows the sign of the residual angle.
    always_comb begin
        x_sh   = x >>> iter;
        y_sh   = y >>> iter;
        atan32 = atan_lut(5'(iter));
        atan_w = atan32[31 -: WIDTH];
        if (!z[WIDTH-1]) begin
            x_step = x - y_sh;
            y_step = y + x_sh;
            z_step = z - atan_w;
        end else begin
            x_step = x + y_sh;
            y_step = y - x_sh;
            z_step = z + atan_w;
        end
    end

    // Datapath, iteration counter and handshake outputs.
    always_ff @(posedge clock) begin
        if (aclr) begin
            x        <= '0;
            y        <= '0;
            z        <= '0;
            iter     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            range_q  <= 1'b0;
            result_q <= '0;
`ifdef CORDIC_SIN_OUT_EN
            result_sin_q <= '0;
`endif
        end else if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        x       <= K_GAIN;
                        y       <= '0;
                        z       <= angle_in;
                        iter    <= '0;
                        range_q <= range_in;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ROTATE: begin
                    x <= x_step;
                    y <= y_step;
                    z <= z_step;
                    if (!last_iter)
                        iter <= iter + 1'b1;
                end
                ST_DONE: begin
                    result_q <= sat_sym(x);
`ifdef CORDIC_SIN_OUT_EN
                    result_sin_q <= sat_sym(y);
`endif
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.range_err = range_q;
    assign bus.result    = result_q;
`ifdef CORDIC_SIN_OUT_EN
    assign bus.result_sin = result_sin_q;
`endif

endmodule
